chain_programmer: RTL and testbench
===================================

Name: chain_programmer

Overview:
- Parametrised successor to the fixed 13-register serial-configuration path of the TDC programmer.
- Takes a flattened register bank of N_REGS x REG_W bits, typically from the I2C CommunicationController.
- Shifts the bank MSB-first into the chip's configuration chain on p_sck/p_sda, then pulses p_scapt to capture it. Provides an explicit chain-reset pulse.
- Also generates the scl-activity comm_busy indicator, with a parametrised timeout and optional pin inversion.

Parameters:
N_REGS, 13, number of configuration registers
REG_W, 8, bits per register
DIV, 4, clkin cycles per half-period of p_sck (>=1)
RST_LEN, 16, clkin cycles p_reset is held high
BUSY_CTR_W, 23, width of the activity counter; comm_busy timeout = 2^(BUSY_CTR_W-1) cycles
INVERT_OUT, 1, 1 = p_* pins driven inverted (open-collector level shifters)

Ports:
clkin  in  1  system clock
rst  in  1  synchronous, active-high reset
scl  in  1  I2C clock, used only for activity monitoring (already synchronised upstream)
cfg_data  in  N_REGS*REG_W  register bank; reg k occupies bits [k*REG_W +: REG_W]
cfg_update  in  1  request a programming pass (level or pulse)
chain_reset_req  in  1  request a p_reset pulse
p_sck  out  1  chain clock
p_sda  out  1  chain data
p_scapt  out  1  capture strobe
p_reset  out  1  chain reset
prog_busy  out  1  high whenever FSM is not IDLE
prog_done  out  1  one-cycle pulse at the end of every programming pass
comm_busy  out  1  high until scl has stayed high for the timeout

Behaviour:
- Clock and reset: single clock clkin. Reset is synchronous, active-high on rst.
- Reset values:
  - Logical sck/sda/scapt/reset = 0; physical pins = INVERT_OUT ? 1 : 0.
  - prog_busy = 0, prog_done = 0.
  - Activity counter = 0, so comm_busy = 1.
  - Pending flags cleared; FSM enters IDLE.
- FSM states:
  - IDLE.
  - RSTP: p_reset high for RST_LEN cycles.
  - SHIFT_LO: sck = 0, sda = current bit, DIV cycles.
  - SHIFT_HI: sck = 1, DIV cycles.
  - CAPT: sck = 0, scapt = 1, DIV cycles.
  - DONE: 1 cycle, prog_done = 1.
- IDLE priority: reset request beats update request.
  - A request sampled high at cycle t gives prog_busy = 1 at t+1.
  - The first bit appears on p_sda at t+1.
  - cfg_data is snapshotted into a TOTAL = N_REGS*REG_W shift register at cycle t.
- Bit order: snapshot bit TOTAL-1 is sent first, down to bit 0. p_sda is stable for the whole low+high period of its bit.
- Bit counting:
  - A bit counter of width clog2(TOTAL) counts SHIFT_HI exits.
  - After the last bit, go to CAPT, not SHIFT_LO.
  - Exactly TOTAL rising p_sck edges occur per pass.
  - Pass length = 2*DIV*TOTAL + DIV + 1 cycles.
- RSTP exits to IDLE. No prog_done is issued for a reset-only pass.
- Requests while busy: cfg_update or chain_reset_req arriving while prog_busy = 1 set a pending flag (one deep each).
  - Pending requests are serviced from IDLE on the cycle after DONE/RSTP completes, reset first.
  - Multiple updates during one pass collapse into one re-pass using cfg_data at that time.
- cfg_data changes mid-pass have no effect on the pass in flight (snapshot only).
- rst mid-pass aborts immediately: all outputs go to their reset values next cycle, and no prog_done is issued.
- Activity counter:
  - scl == 0 clears the counter.
  - Otherwise the counter increments while its MSB is 0 and saturates once the MSB is set.
  - comm_busy = !MSB.

Optional Feature:
CHAIN_AUTO_UPDATE_EN
- Defined:
  - A shadow copy of the last programmed snapshot is kept.
  - When IDLE, comm_busy == 0 and cfg_data != shadow, an internal update request is raised: it behaves exactly like cfg_update.
  - Shadow resets to all-zero, so a non-zero cfg_data auto-programs once the bus goes quiet.
- Undefined: no shadow register; programming occurs only on cfg_update.

Decomposition:
- Package chain_prog_pkg holds:
  - FSM state enum.
  - Helper function clog2.
  - Constants for default DIV and RST_LEN.
- One sub-module, activity_monitor (scl counter + comm_busy), reused by other top-levels.
- Shifter and FSM stay in chain_programmer.

Test Plan:
- N_REGS=2, REG_W=8, DIV=2, INVERT_OUT=0, cfg_data=16'hA55A, cfg_update 1-cycle pulse:
  - p_sda sampled at each p_sck rise = 1010_0101_0101_1010.
  - 16 rises; p_scapt high 2 cycles; prog_done at cycle 67 after request.
- chain_reset_req and cfg_update asserted in the same IDLE cycle, RST_LEN=16:
  - p_reset high exactly 16 cycles, then a full shift pass; one prog_done total.
- Three cfg_update pulses during a pass, cfg_data changed to 16'h00FF mid-pass:
  - First pass shifts the old snapshot.
  - Exactly one extra pass follows, shifting 0000_0000_1111_1111.
- rst asserted at the 5th bit:
  - Next cycle all logical outputs are 0 (INVERT_OUT=1: pins 1); prog_busy = 0; no prog_done.
  - A later cfg_update starts from bit 15.
- BUSY_CTR_W=5, scl toggling then held high:
  - comm_busy stays 1 while toggling, falls exactly 16 cycles after the last scl low.
  - One scl low cycle re-raises it the next cycle.
- CHAIN_AUTO_UPDATE_EN defined, cfg_data=16'h1234, scl held high:
  - A pass starts once comm_busy falls; no second pass while data is unchanged.
  - Changing to 16'h1235 triggers exactly one more pass.

Source files
------------

// File: rtl/chain_prog_pkg.sv
// Shared types and helpers for the serial configuration-chain programmer.
package chain_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RSTP,
    SHIFT_LO,
    SHIFT_HI,
    CAPT,
    DONE
  } state_t;

  localparam int unsigned DEF_DIV     = 4;
  localparam int unsigned DEF_RST_LEN = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/chain_programmer_activity_monitor.sv
// scl activity monitor: comm_busy stays high until scl has been high for
// 2^(CTR_W-1) consecutive clkin cycles.
module activity_monitor #(
  parameter int unsigned CTR_W = 23
) (
  input  logic clkin,
  input  logic rst,
  input  logic scl,
  output logic comm_busy
);

  logic [CTR_W-1:0] ctr;

  // Counter saturates once its MSB is set; any low scl cycle restarts it.
  always_ff @(posedge clkin) begin
    if (rst)                  ctr <= '0;
    else if (!scl)            ctr <= '0;
    else if (!ctr[CTR_W-1])   ctr <= ctr + CTR_W'(1);
  end

  assign comm_busy = !ctr[CTR_W-1];

endmodule

// File: rtl/chain_programmer.sv
// Shifts an N_REGS x REG_W register bank MSB-first into the configuration
// chain, then strobes capture. Optional CHAIN_AUTO_UPDATE_EN reprograms on data change.
module chain_programmer
  import chain_prog_pkg::*;
#(
  parameter int unsigned N_REGS     = 13,
  parameter int unsigned REG_W      = 8,
  parameter int unsigned DIV        = DEF_DIV,
  parameter int unsigned RST_LEN    = DEF_RST_LEN,
  parameter int unsigned BUSY_CTR_W = 23,
  parameter bit          INVERT_OUT = 1'b1
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic                      scl,
  input  logic [N_REGS*REG_W-1:0]   cfg_data,
  input  logic                      cfg_update,
  input  logic                      chain_reset_req,
  output logic                      p_sck,
  output logic                      p_sda,
  output logic                      p_scapt,
  output logic                      p_reset,
  output logic                      prog_busy,
  output logic                      prog_done,
  output logic                      comm_busy
);

  localparam int unsigned TOTAL  = N_REGS * REG_W;
  localparam int unsigned BW     = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL);
  localparam int unsigned MAXLEN = (DIV > RST_LEN) ? DIV : RST_LEN;
  localparam int unsigned PW     = (clog2(MAXLEN) < 1) ? 1 : clog2(MAXLEN);

  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] RST_LAST = PW'(RST_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);

  state_t           state, state_nx;
  logic [PW-1:0]    cnt;
  logic [BW-1:0]    bcnt;
  logic [TOTAL-1:0] sreg;
  logic             pend_upd, pend_rst;
  logic             req_upd, req_rst, auto_req;
  logic             take_upd, take_rst, hi_exit;
  logic             sck_l, sda_l, scapt_l, reset_l;

  activity_monitor #(
    .CTR_W (BUSY_CTR_W)
  ) u_activity (
    .clkin     (clkin),
    .rst       (rst),
    .scl       (scl),
    .comm_busy (comm_busy)
  );

`ifdef CHAIN_AUTO_UPDATE_EN
  logic [TOTAL-1:0] shadow;

  always_ff @(posedge clkin) begin
    if (rst)           shadow <= '0;
    else if (take_upd) shadow <= cfg_data;
  end

  assign auto_req = !comm_busy && (cfg_data != shadow);
`else
  assign auto_req = 1'b0;
`endif

  assign req_rst = chain_reset_req | pend_rst;
  assign req_upd = cfg_update | pend_upd | auto_req;

  always_comb begin
    state_nx = state;
    take_rst = 1'b0;
    take_upd = 1'b0;
    hi_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_rst) begin
          state_nx = RSTP;
          take_rst = 1'b1;
        end else if (req_upd) begin
          state_nx = SHIFT_LO;
          take_upd = 1'b1;
        end
      end
      RSTP:     if (cnt == RST_LAST) state_nx = IDLE;
      SHIFT_LO: if (cnt == DIV_LAST) state_nx = SHIFT_HI;
      SHIFT_HI: begin
        if (cnt == DIV_LAST) begin
          hi_exit  = 1'b1;
          state_nx = (bcnt == BIT_LAST) ? CAPT : SHIFT_LO;
        end
      end
      CAPT:     if (cnt == DIV_LAST) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bcnt     <= '0;
      sreg     <= '0;
      pend_upd <= 1'b0;
      pend_rst <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state || state == IDLE) ? '0 : cnt + PW'(1);
      if (take_upd) begin
        sreg <= cfg_data;
        bcnt <= '0;
      end else if (hi_exit) begin
        sreg <= sreg << 1;
        bcnt <= bcnt + BW'(1);
      end
      // An update arriving alongside a serviced reset is held for the next pass.
      pend_rst <= take_rst ? 1'b0 : (pend_rst | (prog_busy & chain_reset_req));
      pend_upd <= take_upd ? 1'b0 : (pend_upd | ((prog_busy | take_rst) & cfg_update));
    end
  end

  assign sck_l   = (state == SHIFT_HI);
  assign sda_l   = ((state == SHIFT_LO) || (state == SHIFT_HI)) && sreg[TOTAL-1];
  assign scapt_l = (state == CAPT);
  assign reset_l = (state == RSTP);

  assign p_sck     = sck_l   ^ INVERT_OUT;
  assign p_sda     = sda_l   ^ INVERT_OUT;
  assign p_scapt   = scapt_l ^ INVERT_OUT;
  assign p_reset   = reset_l ^ INVERT_OUT;
  assign prog_busy = (state != IDLE);
  assign prog_done = (state == DONE);

endmodule

// File: tb/tb_chain_programmer.sv
// Self-checking bench for chain_programmer (2 x 8-bit bank, DIV=2, inverted pins).
// Builds with or without CHAIN_AUTO_UPDATE_EN.
module tb_chain_programmer;

  localparam int unsigned NR  = 2;
  localparam int unsigned RW  = 8;
  localparam int unsigned TOT = NR * RW;
  localparam int unsigned DV  = 2;
  localparam int unsigned RL  = 16;
  localparam int unsigned BCW = 5;
  localparam bit          INV = 1'b1;
  localparam int PASS_LEN = 2 * DV * TOT + DV + 1;
  localparam int QUIET    = 1 << (BCW - 1);

  logic          clkin = 1'b0;
  logic          rst, scl, cfg_update, chain_reset_req;
  logic [15:0]   cfg_data;
  logic          p_sck, p_sda, p_scapt, p_reset, prog_busy, prog_done, comm_busy;

  int checks = 0;
  int errors = 0;

  logic bitq[$];
  int   done_k[$];
  int   n_rise, n_capt, n_rst, n_busy, first_rst, first_busy;
  logic sda_k1;

  chain_programmer #(
    .N_REGS     (NR),
    .REG_W      (RW),
    .DIV        (DV),
    .RST_LEN    (RL),
    .BUSY_CTR_W (BCW),
    .INVERT_OUT (INV)
  ) dut (
    .clkin           (clkin),
    .rst             (rst),
    .scl             (scl),
    .cfg_data        (cfg_data),
    .cfg_update      (cfg_update),
    .chain_reset_req (chain_reset_req),
    .p_sck           (p_sck),
    .p_sda           (p_sda),
    .p_scapt         (p_scapt),
    .p_reset         (p_reset),
    .prog_busy       (prog_busy),
    .prog_done       (prog_done),
    .comm_busy       (comm_busy)
  );

  always #5 clkin = ~clkin;

  // Records chain activity over a fixed window; k=1 is the cycle after the request edge.
  task automatic observe(input int ncyc);
    logic prev;
    bitq.delete();
    done_k.delete();
    n_rise = 0; n_capt = 0; n_rst = 0; n_busy = 0;
    first_rst = -1; first_busy = -1; sda_k1 = 1'bx;
    prev = p_sck ^ INV;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clkin);
      if (k == 1) sda_k1 = p_sda ^ INV;
      if ((p_sck ^ INV) && !prev) begin
        n_rise++;
        bitq.push_back(p_sda ^ INV);
      end
      prev = p_sck ^ INV;
      if (p_scapt ^ INV) n_capt++;
      if (p_reset ^ INV) begin
        n_rst++;
        if (first_rst < 0) first_rst = k;
      end
      if (prog_busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = k;
      end
      if (prog_done) done_k.push_back(k);
    end
  endtask

  function automatic logic [15:0] packq(input int from);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r = {r[14:0], (from + i < bitq.size()) ? bitq[from + i] : 1'bx};
    return r;
  endfunction

  function automatic int done_at(input int idx);
    return (idx < done_k.size()) ? done_k[idx] : -1;
  endfunction

  task automatic pulse_update();
    @(negedge clkin);
    cfg_update = 1'b1;
    @(posedge clkin);
    #1 cfg_update = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clkin);
    checks++;
    if ({p_sck, p_sda, p_scapt, p_reset} !== {4{INV}}) begin
      errors++;
      $display("FAIL reset_pins: got %b expected %b", {p_sck, p_sda, p_scapt, p_reset}, {4{INV}});
    end
    checks++;
    if ({prog_busy, prog_done, comm_busy} !== 3'b001) begin
      errors++;
      $display("FAIL reset_status: got busy/done/comm %b expected 001", {prog_busy, prog_done, comm_busy});
    end
    rst = 1'b0;
    @(negedge clkin);
    checks++;
    if (prog_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got prog_busy %b expected 0", prog_busy);
    end
  endtask

  task automatic test_single_pass(input logic [15:0] d, input string nm);
    cfg_data = d;
    pulse_update();
    observe(PASS_LEN + 10);
    checks++;
    if (first_busy !== 1 || sda_k1 !== d[15]) begin
      errors++;
      $display("FAIL %s_start: got busy@%0d sda %b expected busy@1 sda %b", nm, first_busy, sda_k1, d[15]);
    end
    checks++;
    if (n_rise !== TOT) begin
      errors++;
      $display("FAIL %s_rises: got %0d expected %0d", nm, n_rise, TOT);
    end
    checks++;
    if (packq(0) !== d) begin
      errors++;
      $display("FAIL %s_bits: got %h expected %h", nm, packq(0), d);
    end
    checks++;
    if (n_capt !== DV) begin
      errors++;
      $display("FAIL %s_capt: got %0d cycles expected %0d", nm, n_capt, DV);
    end
    checks++;
    if (done_k.size() !== 1 || done_at(0) !== PASS_LEN) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses first@%0d expected 1 @%0d", nm, done_k.size(), done_at(0), PASS_LEN);
    end
    checks++;
    if (n_busy !== PASS_LEN || n_rst !== 0) begin
      errors++;
      $display("FAIL %s_busy: got busy %0d reset %0d expected %0d 0", nm, n_busy, n_rst, PASS_LEN);
    end
  endtask

  task automatic test_reset_and_update();
    logic [15:0] d;
    d = 16'($urandom);
    cfg_data = d;
    @(negedge clkin);
    cfg_update = 1'b1;
    chain_reset_req = 1'b1;
    @(posedge clkin);
    #1 cfg_update = 1'b0;
    chain_reset_req = 1'b0;
    observe(RL + 1 + PASS_LEN + 10);
    checks++;
    if (first_rst !== 1 || n_rst !== RL) begin
      errors++;
      $display("FAIL rstupd_reset: got first %0d len %0d expected 1 %0d", first_rst, n_rst, RL);
    end
    checks++;
    if (done_k.size() !== 1 || done_at(0) !== RL + 1 + PASS_LEN) begin
      errors++;
      $display("FAIL rstupd_done: got %0d pulses @%0d expected 1 @%0d", done_k.size(), done_at(0), RL + 1 + PASS_LEN);
    end
    checks++;
    if (n_rise !== TOT || packq(0) !== d) begin
      errors++;
      $display("FAIL rstupd_bits: got %0d rises %h expected %0d %h", n_rise, packq(0), TOT, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0, d1;
    d0 = 16'($urandom);
    d1 = 16'h00FF;
    cfg_data = d0;
    pulse_update();
    fork
      observe(2 * PASS_LEN + 20);
      begin
        repeat (9) @(posedge clkin);
        #1 cfg_update = 1'b1;
        @(posedge clkin);
        #1 cfg_update = 1'b0;
        repeat (10) @(posedge clkin);
        #1 cfg_data = d1;
        for (int p = 0; p < 2; p++) begin
          repeat (8 + $urandom_range(0, 4)) @(posedge clkin);
          #1 cfg_update = 1'b1;
          @(posedge clkin);
          #1 cfg_update = 1'b0;
        end
      end
    join
    checks++;
    if (done_k.size() !== 2 || done_at(0) !== PASS_LEN || done_at(1) !== 2 * PASS_LEN + 1) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses @%0d,@%0d expected 2 @%0d,@%0d",
               done_k.size(), done_at(0), done_at(1), PASS_LEN, 2 * PASS_LEN + 1);
    end
    checks++;
    if (n_rise !== 2 * TOT) begin
      errors++;
      $display("FAIL b2b_rises: got %0d expected %0d", n_rise, 2 * TOT);
    end
    checks++;
    if (packq(0) !== d0) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", packq(0), d0);
    end
    checks++;
    if (packq(TOT) !== d1) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", packq(TOT), d1);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    d = 16'($urandom);
    cfg_data = d;
    pulse_update();
    // Bit index 4 (the 5th bit) is in its low phase on cycles 17-18.
    repeat (18) @(negedge clkin);
    checks++;
    if (prog_busy !== 1'b1 || (p_sda ^ INV) !== d[11]) begin
      errors++;
      $display("FAIL abort_bit5: got busy %b sda %b expected 1 %b", prog_busy, p_sda ^ INV, d[11]);
    end
    rst = 1'b1;
    @(negedge clkin);
    checks++;
    if ({p_sck, p_sda, p_scapt, p_reset} !== {4{INV}} || prog_busy !== 1'b0 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got pins %b busy %b done %b expected %b 0 0",
               {p_sck, p_sda, p_scapt, p_reset}, prog_busy, prog_done, {4{INV}});
    end
    rst = 1'b0;
    observe(PASS_LEN + 5);
    checks++;
    if (done_k.size() !== 0 || n_busy !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d done %0d busy expected 0 0", done_k.size(), n_busy);
    end
    test_single_pass(16'($urandom), "post_abort");
  endtask

  task automatic test_activity();
    int j;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin);
      checks++;
      if (comm_busy !== 1'b1) begin
        errors++;
        $display("FAIL act_toggle: got comm_busy %b at %0d expected 1", comm_busy, i);
      end
      scl = (i % 8 == 7) ? 1'b0 : 1'($urandom);
    end
    @(negedge clkin);
    scl = 1'b0;
    @(negedge clkin);
    scl = 1'b1;
    j = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clkin);
      if (!comm_busy) begin
        j = k;
        break;
      end
    end
    checks++;
    if (j !== QUIET) begin
      errors++;
      $display("FAIL act_timeout: got fall after %0d expected %0d", j, QUIET);
    end
    scl = 1'b0;
    @(negedge clkin);
    checks++;
    if (comm_busy !== 1'b1) begin
      errors++;
      $display("FAIL act_reraise: got comm_busy %b expected 1", comm_busy);
    end
    scl = 1'b0;
  endtask

`ifdef CHAIN_AUTO_UPDATE_EN
  task automatic test_auto_update();
    @(negedge clkin);
    rst = 1'b1;
    cfg_data = 16'h1234;
    @(negedge clkin);
    rst = 1'b0;
    scl = 1'b1;
    observe(QUIET + PASS_LEN + 20);
    checks++;
    if (first_busy !== QUIET + 1) begin
      errors++;
      $display("FAIL auto_start: got busy@%0d expected @%0d", first_busy, QUIET + 1);
    end
    checks++;
    if (done_k.size() !== 1 || packq(0) !== 16'h1234) begin
      errors++;
      $display("FAIL auto_first: got %0d passes %h expected 1 1234", done_k.size(), packq(0));
    end
    observe(100);
    checks++;
    if (n_busy !== 0) begin
      errors++;
      $display("FAIL auto_stable: got %0d busy cycles expected 0", n_busy);
    end
    cfg_data = 16'h1235;
    observe(PASS_LEN + 20);
    checks++;
    if (done_k.size() !== 1 || packq(0) !== 16'h1235) begin
      errors++;
      $display("FAIL auto_change: got %0d passes %h expected 1 1235", done_k.size(), packq(0));
    end
    scl = 1'b0;
  endtask
`else
  task automatic test_auto_update();
    cfg_data = 16'h1234;
    scl = 1'b1;
    observe(QUIET + PASS_LEN + 20);
    checks++;
    if (n_busy !== 0 || done_k.size() !== 0) begin
      errors++;
      $display("FAIL no_auto: got %0d busy %0d done expected 0 0", n_busy, done_k.size());
    end
    scl = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    scl = 1'b0;
    cfg_update = 1'b0;
    chain_reset_req = 1'b0;
    cfg_data = '0;
    test_reset();
    test_single_pass(16'hA55A, "pass_a55a");
    test_single_pass(16'($urandom), "pass_rand0");
    test_single_pass(16'($urandom), "pass_rand1");
    test_reset_and_update();
    test_back_to_back();
    test_abort();
    test_activity();
    test_auto_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
